alu_mc: RTL and testbench

- Parametrised, registered, multi-cycle successor to the combinational CPU ALU.
- Adds a valid/ready handshake on input and output, iterative unsigned multiply, and optional unsigned divide/remainder.
- Sits between the operand-fetch stage and writeback. The pipeline stalls on in_ready/out_valid instead of assuming single-cycle results.

---
 rtl/alu_mc.sv | 159 +++++++++++++++
 tb/tb_alu_mc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, shift-add multiply and optional restoring divide.
// Define ALU_MC_DIV_EN to build the DIV state and divider datapath (sel 9/10); otherwise they are reserved.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

  state_t          state;
  logic [SHW:0]    cnt;
  logic [WIDTH-1:0] a;    // multiplicand (MUL) / dividend shifting into quotient (DIV)
  logic [WIDTH-1:0] b;    // multiplier (MUL) / divisor (DIV)
  logic [WIDTH-1:0] acc;  // product (MUL) / partial remainder (DIV)
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] mul_nxt;
  logic             accept;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_nxt  = acc + (b[0] ? a : '0);

  always_comb begin
    res = '0;
    case (sel)
      OP_ADD:  res = inp1 + inp2;
      OP_SUB:  res = inp1 - inp2;
      OP_AND:  res = inp1 & inp2;
      OP_OR:   res = inp1 | inp2;
      OP_XOR:  res = inp1 ^ inp2;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(inp1) < $signed(inp2))};
      OP_SLL:  res = inp1 << inp2[SHW-1:0];
      OP_SRL:  res = inp1 >> inp2[SHW-1:0];
      default: res = '0;
    endcase
  end

`ifdef ALU_MC_DIV_EN
  logic             is_rem;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] div_res;

  // Divisor 0 never borrows, so the quotient fills with ones and the remainder ends as the dividend.
  assign rem_sh    = {acc, a[WIDTH-1]};
  assign diff      = rem_sh - {1'b0, b};
  assign no_borrow = !diff[WIDTH];
  assign rem_nxt   = no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign q_nxt     = {a[WIDTH-2:0], no_borrow};
  assign div_res   = is_rem ? rem_nxt : q_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      acc       <= '0;
      out       <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
`ifdef ALU_MC_DIV_EN
      is_rem    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            cnt <= '0;
            a   <= inp1;
            b   <= inp2;
            acc <= '0;
            if (sel == OP_MUL) begin
              state     <= MUL;
              out_valid <= 1'b0;
            end
`ifdef ALU_MC_DIV_EN
            else if (sel == OP_DIVU || sel == OP_REMU) begin
              state     <= DIV;
              out_valid <= 1'b0;
              is_rem    <= (sel == OP_REMU);
            end
`endif
            else begin
              state     <= DONE;
              out       <= res;
              zero      <= (res == '0);
              out_valid <= 1'b1;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc <= mul_nxt;
          a   <= {a[WIDTH-2:0], 1'b0};
          b   <= {1'b0, b[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            out       <= mul_nxt;
            zero      <= (mul_nxt == '0);
            out_valid <= 1'b1;
          end
        end
`ifdef ALU_MC_DIV_EN
        DIV: begin
          acc <= rem_nxt;
          a   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            out       <= div_res;
            zero      <= (div_res == '0);
            out_valid <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results queued at drive time, popped when out_valid appears.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] inp1 = '0;
  logic [W-1:0] inp2 = '0;
  logic [3:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic         zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] val;
    int           lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inp1(inp1), .inp2(inp2), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zero(zero)
  );

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [3:0] s);
    logic [W-1:0] r;
    case (s)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: r = x << y[4:0];
      4'd7: r = x >> y[4:0];
      4'd8: r = x * y;
`ifdef ALU_MC_DIV_EN
      4'd9:  r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd10: r = (y == 0) ? x : x % y;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [3:0] s);
`ifdef ALU_MC_DIV_EN
    if (s == 4'd9 || s == 4'd10) return W + 1;
`endif
    return (s == 4'd8) ? W + 1 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] s);
    exp_t e;
    in_valid = 1'b1;
    inp1 = x;
    inp2 = y;
    sel = s;
    e.val = model(x, y, s);
    e.lat = lat_of(s);
    sb.push_back(e);
  endtask

  // Called just after the accept edge; counts edges from accept (inclusive) to out_valid.
  task automatic wait_valid(input int budget, output int edges);
    edges = 1;
    while (!out_valid && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL reset_out: got %h want 0", out); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero: got %b want 1", zero); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid2: got %b want 0", out_valid); end
  endtask

  task automatic test_add();
    exp_t e;
    int edges;
    out_ready = 1'b1;
    drive(32'd2, 32'd5, 4'd0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    wait_valid(10, edges);
    e = sb.pop_front();
    n_cmp++; if (edges != e.lat || out_valid !== 1'b1) begin n_bad++; $display("FAIL add_latency: got %0d want %0d", edges, e.lat); end
    n_cmp++; if (out !== e.val) begin n_bad++; $display("FAIL add_out: got %h want %h", out, e.val); end
    n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL add_zero: got %b want 0", zero); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [10] = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'h0000_F0F0, 32'h0000_F0F0,
                              32'hAAAA_AAAA, 32'd1, 32'h8000_0000, 32'd7, 32'd3};
    logic [W-1:0] tb [10] = '{32'd5, 32'd1, 32'hFFFF_FFFF, 32'h0000_0FF0, 32'h0000_0FF0,
                              32'hAAAA_AAAA, 32'd31, 32'd31, 32'd3, 32'd7};
    logic [3:0]   ts [10] = '{4'd1, 4'd5, 4'd5, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd0, 4'd1};
    exp_t e;
    logic [3:0] s;
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 10) begin
        drive(ta[i], tb[i], ts[i]);
      end else begin
        s = 4'($urandom_range(0, 12));
        if (s > 4'd7) s = s + 4'd3;
        drive($urandom, $urandom, s);
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      e = sb.pop_front();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out !== e.val) begin n_bad++; $display("FAIL b2b_out[%0d] sel=%0d: got %h want %h", i, sel, out, e.val); end
      n_cmp++; if (zero !== (e.val == '0)) begin n_bad++; $display("FAIL b2b_zero[%0d]: got %b want %b", i, zero, (e.val == '0)); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    logic [W-1:0] ma [4] = '{32'd18, 32'hFFFF_FFFF, 32'd0, 32'h0001_2345};
    logic [W-1:0] mb [4] = '{32'd24, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_6789};
    exp_t e;
    int edges;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(ma[i], mb[i], 4'd8);
      else drive($urandom, $urandom, 4'd8);
      tick();
      edges = 1;
      while (!out_valid && edges < 100) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mul_busy_ready[%0d]: got %b want 0 at edge %0d", i, in_ready, edges); end
        // Garbage requests while busy must be ignored.
        in_valid = (edges < 20);
        inp1 = $urandom;
        inp2 = $urandom;
        sel = 4'($urandom_range(0, 7));
        tick();
        edges++;
      end
      in_valid = 1'b0;
      e = sb.pop_front();
      n_cmp++; if (edges != e.lat) begin n_bad++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, edges, e.lat); end
      n_cmp++; if (out !== e.val) begin n_bad++; $display("FAIL mul_out[%0d]: got %h want %h", i, out, e.val); end
      n_cmp++; if (zero !== (e.val == '0)) begin n_bad++; $display("FAIL mul_zero[%0d]: got %b want %b", i, zero, (e.val == '0)); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mul_retire[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_div();
    logic [W-1:0] da [8] = '{32'd100, 32'd100, 32'd9, 32'd9, 32'd1, 32'hFFFF_FFFF, 32'd3, 32'd8};
    logic [W-1:0] db [8] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd1, 32'd16, 32'd4, 32'd8};
    logic [3:0]   ds [8] = '{4'd9, 4'd10, 4'd9, 4'd10, 4'd0, 4'd9, 4'd0, 4'd15};
    exp_t e;
    int edges;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(da[i], db[i], ds[i]);
      tick();
      in_valid = 1'b0;
      wait_valid(100, edges);
      e = sb.pop_front();
      n_cmp++; if (edges != e.lat || out_valid !== 1'b1) begin n_bad++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, edges, e.lat); end
      n_cmp++; if (out !== e.val) begin n_bad++; $display("FAIL div_out[%0d] sel=%0d: got %h want %h", i, ds[i], out, e.val); end
      n_cmp++; if (zero !== (e.val == '0)) begin n_bad++; $display("FAIL div_zero[%0d]: got %b want %b", i, zero, (e.val == '0)); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    drive(32'd3, 32'd4, 4'd0);
    tick();
    e = sb.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || out !== e.val) begin n_bad++; $display("FAIL bp_first: got v=%b %h want v=1 %h", out_valid, out, e.val); end
    drive(32'd10, 32'd20, 4'd0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out !== e.val) begin n_bad++; $display("FAIL bp_out[%0d]: got %h want %h", i, out, e.val); end
      n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL bp_zero[%0d]: got %b want 0", i, zero); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || out !== e.val) begin n_bad++; $display("FAIL bp_same_edge: got v=%b %h want v=1 %h", out_valid, out, e.val); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    logic seen;
    out_ready = 1'b1;
    drive(32'd1234, 32'd5678, 4'd8);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    e = sb.pop_front();
    n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL midrst_out: got %h want 0", out); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL midrst_zero: got %b want 1", zero); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (45) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_stale: got %b want 0 (abandoned %h)", seen, e.val); end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
